// File: rtl/topk_pkg.sv
// topk_pkg: shared entry/state types and the rank-compare helper for topk_bubble.
package topk_pkg;
  localparam int TOPK_DW = 11;
  localparam int TOPK_DN = 15486;
  localparam int TOPK_IW = $clog2(TOPK_DN);
  localparam int MAX_DW = 32;
  typedef struct packed {
    logic vld;
    logic [TOPK_DW-1:0] data;
    logic [TOPK_IW-1:0] idx;
  } topk_entry_t;
  typedef enum logic {ACCUM, EMIT} topk_state_t;
  function automatic logic better(input logic [MAX_DW-1:0] a, input logic [MAX_DW-1:0] b, input logic mode_min);
    return mode_min ? (a < b) : (a > b);
  endfunction
endpackage

// File: rtl/topk_slot.sv
// topk_slot: one ranked entry; takes the new sample, takes the entry above, or holds.
module topk_slot
  import topk_pkg::*;
#(
  parameter int DW = 11,
  parameter int IW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ins,
  input  logic          mode_min,
  input  logic [DW-1:0] new_data,
  input  logic [IW-1:0] new_idx,
  input  logic          up_win,
  input  logic          up_vld,
  input  logic [DW-1:0] up_data,
  input  logic [IW-1:0] up_idx,
  output logic          win,
  output logic          vld,
  output logic [DW-1:0] data,
  output logic [IW-1:0] idx
);
  typedef struct packed {
    logic vld;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } entry_t;
  entry_t q;
  // Strict compare keeps the earlier sample ahead on ties.
  assign win = !q.vld || better(MAX_DW'(new_data), MAX_DW'(q.data), mode_min);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (ins && up_win) q <= '{up_vld, up_data, up_idx};
    else if (ins && win) q <= '{1'b1, new_data, new_idx};
  assign vld = q.vld;
  assign data = q.data;
  assign idx = q.idx;
endmodule

// File: rtl/topk_bubble.sv
// topk_bubble: keeps the K best samples of a framed stream and emits them ranked after in_last.
// Optional TOPK_OVF_CHECK_EN adds frame_ovf for frames longer than DATA_NUM.
module topk_bubble
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int DATA_NUM = 15486,
  parameter int INDEX_WIDTH = $clog2(DATA_NUM),
  parameter int K = 4,
  parameter int RANK_WIDTH = (K > 1) ? $clog2(K) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   this_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  input  logic                   mode_min,
  output logic                   out_valid,
  input  logic                   next_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [RANK_WIDTH-1:0]  out_rank,
  output logic                   out_last
`ifdef TOPK_OVF_CHECK_EN
  ,
  output logic                   frame_ovf
`endif
);
  topk_state_t state;
  logic [INDEX_WIDTH-1:0] cnt;
  logic [RANK_WIDTH-1:0] rank;
  logic mid, mode_q, accept, mode_eff, done, unused;
  logic [K:0] win_x;
  logic [K+1:0] vld_x;
  logic [DATA_WIDTH-1:0] data_x [K+1];
  logic [INDEX_WIDTH-1:0] idx_x [K+1];
  logic [DATA_WIDTH-1:0] ent_data [K];
  logic [INDEX_WIDTH-1:0] ent_idx [K];
  logic [K-1:0] last_vec;
  assign accept = in_valid && this_ready;
  assign mode_eff = mid ? mode_q : mode_min;
  assign done = out_valid && next_ready && out_last;
  assign win_x[0] = 1'b0;
  assign vld_x[0] = 1'b0;
  assign vld_x[K+1] = 1'b0;
  assign data_x[0] = '0;
  assign idx_x[0] = '0;
  assign unused = win_x[K];
  // Slot i sees slot i-1 through the *_x chains; index 0 is a constant empty slot.
  for (genvar i = 0; i < K; i++) begin : g_slot
    topk_slot #(.DW(DATA_WIDTH), .IW(INDEX_WIDTH)) u_slot (
      .clk(clk),
      .rst(rst),
      .clr(done),
      .ins(accept),
      .mode_min(mode_eff),
      .new_data(in_data),
      .new_idx(cnt),
      .up_win(win_x[i]),
      .up_vld(vld_x[i]),
      .up_data(data_x[i]),
      .up_idx(idx_x[i]),
      .win(win_x[i+1]),
      .vld(vld_x[i+1]),
      .data(data_x[i+1]),
      .idx(idx_x[i+1])
    );
    assign ent_data[i] = data_x[i+1];
    assign ent_idx[i] = idx_x[i+1];
    assign last_vec[i] = !vld_x[i+2];
  end
  assign out_data = out_valid ? ent_data[rank] : '0;
  assign out_index = out_valid ? ent_idx[rank] : '0;
  assign out_rank = out_valid ? rank : '0;
  assign out_last = out_valid && last_vec[rank];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ACCUM;
      this_ready <= 1'b0;
      out_valid <= 1'b0;
      cnt <= '0;
      rank <= '0;
      mid <= 1'b0;
      mode_q <= 1'b0;
    end else if (state == ACCUM) begin
      this_ready <= !(accept && in_last);
      if (accept) begin
        mid <= 1'b1;
        mode_q <= mode_eff;
        cnt <= (cnt == INDEX_WIDTH'(DATA_NUM - 1)) ? cnt : cnt + 1'b1;
        if (in_last) begin
          state <= EMIT;
          out_valid <= 1'b1;
        end
      end
    end else if (out_valid && next_ready) begin
      rank <= rank + 1'b1;
      if (out_last) begin
        state <= ACCUM;
        out_valid <= 1'b0;
        this_ready <= 1'b1;
        rank <= '0;
        cnt <= '0;
        mid <= 1'b0;
      end
    end
`ifdef TOPK_OVF_CHECK_EN
  logic sat;
  // sat marks that index DATA_NUM-1 is taken; any later beat is an overflow.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sat <= 1'b0;
      frame_ovf <= 1'b0;
    end else if (done) begin
      sat <= 1'b0;
      frame_ovf <= 1'b0;
    end else if (accept) begin
      if (cnt == INDEX_WIDTH'(DATA_NUM - 1)) sat <= 1'b1;
      if (sat) frame_ovf <= 1'b1;
    end
  a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(accept && sat))
    else $error("topk_bubble: frame longer than DATA_NUM beats");
`endif
endmodule

// File: tb/tb_topk_bubble.sv
// tb_topk_bubble: randomized frames checked against a sort-based top-K reference model.
module tb_topk_bubble;
  localparam int DW = 11;
  localparam int DN = 15486;
  localparam int IW = $clog2(DN);
  localparam int K = 4;
  localparam int RW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic mode_min = 1'b0;
  logic next_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic this_ready, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic [RW-1:0] out_rank;
  int n_cmp = 0;
  int n_err = 0;
  int exp_d[$];
  int exp_i[$];
  topk_bubble dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .this_ready(this_ready),
    .in_data(in_data),
    .in_last(in_last),
    .mode_min(mode_min),
    .out_valid(out_valid),
    .next_ready(next_ready),
    .out_data(out_data),
    .out_index(out_index),
    .out_rank(out_rank),
    .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Reference: repeatedly pick the best unused sample, earliest index winning ties.
  task automatic model(input int d[$], input bit mn);
    bit used [64];
    exp_d.delete();
    exp_i.delete();
    foreach (used[j]) used[j] = 1'b0;
    for (int r = 0; r < K && r < d.size(); r++) begin
      int b = -1;
      for (int j = 0; j < d.size(); j++)
        if (!used[j] && (b < 0 || (mn ? d[j] < d[b] : d[j] > d[b]))) b = j;
      used[b] = 1'b1;
      exp_d.push_back(d[b]);
      exp_i.push_back(b < DN ? b : DN - 1);
    end
  endtask
  task automatic send(input int d[$], input bit mn);
    foreach (d[j]) begin
      @(negedge clk);
      check("this_ready accum", 32'(this_ready), 1);
      in_valid = 1'b1;
      in_data = DW'(d[j]);
      in_last = (j == d.size() - 1);
      mode_min = (j == 0) ? mn : 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("out_valid latency", 32'(out_valid), 1);
  endtask
  task automatic collect(input int pct);
    int r = 0;
    int cyc = 0;
    while (r < exp_d.size() && cyc < 500) begin
      check("this_ready emit", 32'(this_ready), 0);
      check($sformatf("out_valid r%0d", r), 32'(out_valid), 1);
      check($sformatf("out_data r%0d", r), 32'(out_data), exp_d[r]);
      check($sformatf("out_index r%0d", r), 32'(out_index), exp_i[r]);
      check($sformatf("out_rank r%0d", r), 32'(out_rank), r);
      check($sformatf("out_last r%0d", r), 32'(out_last), 32'(r == exp_d.size() - 1));
      next_ready = ($urandom_range(0, 99) < pct);
      if (next_ready) r++;
      @(negedge clk);
      cyc++;
    end
    next_ready = 1'b0;
    check("emit count", r, exp_d.size());
    check("out_valid after emit", 32'(out_valid), 0);
    check("this_ready after emit", 32'(this_ready), 1);
  endtask
  task automatic run(input int d[$], input bit mn, input int pct);
    model(d, mn);
    send(d, mn);
    collect(pct);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int f[$];
    repeat (2) @(negedge clk);
    check("reset this_ready", 32'(this_ready), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", 32'(out_data), 0);
    check("reset out_index", 32'(out_index), 0);
    check("reset out_rank", 32'(out_rank), 0);
    check("reset out_last", 32'(out_last), 0);
    rst = 1'b0;
    @(negedge clk);
    check("this_ready post reset", 32'(this_ready), 1);
    f = '{5, 900, 17, 900, 3, 1200};
    run(f, 1'b0, 100);
    f = '{42};
    run(f, 1'b0, 100);
    f = '{2047, 10, 10, 0, 500};
    run(f, 1'b1, 100);
    f = '{7, 9};
    run(f, 1'b0, 60);
    for (int n = 0; n < 5; n++) begin
      int len = $urandom_range(2, 20);
      f.delete();
      for (int j = 0; j < len; j++)
        f.push_back((n % 2) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 7)));
      run(f, 1'($urandom_range(0, 1)), 70);
    end
    // Abandon a frame after three beats with a reset; nothing of it may survive.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = DW'(2000 + j);
      in_last = 1'b0;
      mode_min = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midframe reset this_ready", 32'(this_ready), 0);
    check("midframe reset out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    f = '{1, 2, 3, 4, 5};
    run(f, 1'b0, 70);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/topk_bubble.md
Name: topk_bubble

Overview:
- Parametrised successor of the single-maximum stream finder.
- Consumes one framed stream (valid/ready, in_last) and keeps a sorted list of the K best samples with their in-frame indices.
- After the last beat it emits K (or fewer) ranked results on a valid/ready output port.
- Per-frame mode selects max-K or min-K. Sits between the sample-capture stream and the peak-report logic.

Parameters:
- DATA_WIDTH, 11, unsigned sample width.
- DATA_NUM, 15486, maximum beats per frame.
- INDEX_WIDTH, $clog2(DATA_NUM), width of sample index.
- K, 4, number of ranked results kept (1..16).
- RANK_WIDTH, $clog2(K) (min 1), width of rank output.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream sample valid.
- this_ready  out  1  block accepts a sample.
- in_data  in  DATA_WIDTH  sample.
- in_last  in  1  final sample of frame.
- mode_min  in  1  0 = largest K, 1 = smallest K; sampled on the first beat of each frame.
- out_valid  out  1  result valid.
- next_ready  in  1  downstream accepts result.
- out_data  out  DATA_WIDTH  ranked sample value.
- out_index  out  INDEX_WIDTH  in-frame index of that sample.
- out_rank  out  RANK_WIDTH  0 = best.
- out_last  out  1  final result of frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. Reset clears all state at any time, including mid-frame or mid-emit; partial frames are discarded.
- Reset values: this_ready=0 during reset, 1 after; out_valid=0, out_data=0, out_index=0, out_rank=0, out_last=0; entry valid bits=0; counters=0; state=ACCUM.
- FSM ACCUM:
  - this_ready=1, out_valid=0.
  - On in_valid&&this_ready, insert the sample at index = beat counter. The beat counter resets to 0 at each frame start.
  - On an accepted in_last, go to EMIT next cycle.
- FSM EMIT:
  - this_ready=0.
  - out_valid=1, presenting entry[rank].
  - Advance rank on out_valid&&next_ready.
  - After the handshake with out_last=1, clear all entries, reset counters, return to ACCUM.
- Latency: out_valid rises the cycle after the in_last handshake. Throughput is one sample per cycle in ACCUM.
- Insertion:
  - Parallel compare of the new sample against all K entries.
  - "Better" means strictly greater (max mode) or strictly less (min mode).
  - The new entry lands at the first slot that is invalid or worse than it; lower slots shift down by one; the entry in slot K-1 falls off.
  - Ties: the earlier index keeps the higher rank (strict compare). With K=1 this reproduces the first-occurrence max.
- Emit count: min(frame length, K). out_last is on rank count-1.
- Single-beat frame: one result, rank 0, out_last=1.
- Frames longer than DATA_NUM: the index saturates at DATA_NUM-1. Results are still produced.
- mode_min: latched with the first accepted beat. Changes mid-frame are ignored.
- Output stability: output signals hold steady while out_valid&&!next_ready.

Optional Feature:
- Macro: TOPK_OVF_CHECK_EN.
- Defined: add output port frame_ovf (1 bit, reset 0).
  - frame_ovf goes high when a beat is accepted with the beat counter already at DATA_NUM-1.
  - It stays high through the EMIT of that frame and clears on return to ACCUM.
  - A $error assertion fires in simulation.
- Undefined: no port, no check; saturation behaviour is unchanged.

Decomposition:
- Package topk_pkg holds:
  - typedef struct packed {logic vld; logic [DATA_WIDTH-1:0] data; logic [INDEX_WIDTH-1:0] idx;} topk_entry_t, parametrised through package localparams or a module-level typedef.
  - typedef enum {ACCUM, EMIT} topk_state_t.
  - A compare function better(a,b,mode_min).
- Sub-module topk_slot: one register entry with compare, take-new / take-upper / hold muxing. Instantiate K times in a generate loop.

Test Plan:
- K=4, max mode, frame [5,900,17,900,3,1200] -> results (1200,5),(900,1),(900,3),(17,2), ranks 0..3, out_last on rank 3; tie order is checked.
- Single beat 42, mode_min=0 -> one result (42,0), rank 0, out_last=1; out_valid one cycle after the handshake.
- mode_min=1, frame [2047,10,10,0,500] -> (0,3),(10,1),(10,2),(500,4). Then a 2-beat max frame [7,9] -> (9,1),(7,0), out_last on rank 1.
- Random next_ready at 70%, 5 random frames of length 2..20 -> all results match the reference model; out_* stable while stalled; this_ready=0 throughout EMIT.
- Assert rst mid-frame after 3 beats, then send a full frame [1,2,3,4,5] -> only (5,4),(4,3),(3,2),(2,1); no stale results.
- With TOPK_OVF_CHECK_EN and DATA_NUM=8, send a 10-beat frame -> frame_ovf=1 during EMIT; indices saturate at 7; frame_ovf clears after out_last.
